// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OpMult  = 2'd0,
        OpMultu = 2'd1,
        OpDiv   = 2'd2,
        OpDivu  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCalc   = 2'd1,
        StFinish = 2'd2
    } state_e;

    function automatic logic is_signed_op(input op_e op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    function automatic logic is_div_op(input op_e op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle on operand magnitudes,
// sign fix-up in a final cycle, results held in architectural HI/LO.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q, b_q, a_mag_q, b_mag_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     rem_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;

    op_e              op_in;
    logic             op_in_signed;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;

    assign op_in        = op_e'(op);
    assign op_in_signed = is_signed_op(op_in);
    assign a_mag_in     = (op_in_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    assign b_mag_in     = (op_in_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

    // Shift-add step: the carry out of the upper half lands in the MSB after the shift.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);

    // Restoring-division step; the quotient shifts through the low half of acc_q.
    logic [WIDTH:0] div_shift, div_rem;
    logic           div_ge;
    assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, b_mag_q};
    assign div_rem   = div_ge ? (div_shift - {1'b0, b_mag_q}) : div_shift;

    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fin_hi, fin_lo;
    logic               div_zero, sign_diff;

    always_comb begin
        sign_diff = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        div_zero  = (b_q == '0);
        prod_fix  = (op_q == OpMult && sign_diff) ? -acc_q : acc_q;
        quo_fix   = (op_q == OpDiv && sign_diff) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = (op_q == OpDiv && a_q[WIDTH-1]) ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        fin_hi    = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo    = prod_fix[WIDTH-1:0];
        if (is_div_op(op_q)) begin
            fin_hi = div_zero ? a_q : rem_fix;
            fin_lo = div_zero ? '1 : quo_fix;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StCalc;
            StCalc:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q    <= OpMult;
            a_q     <= '0;
            b_q     <= '0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (hi_write) hi_q <= write_data;
                    if (lo_write) lo_q <= write_data;
                    if (start) begin
                        op_q    <= op_in;
                        a_q     <= operand_a;
                        b_q     <= operand_b;
                        a_mag_q <= a_mag_in;
                        b_mag_q <= b_mag_in;
                        acc_q   <= {{WIDTH{1'b0}}, is_div_op(op_in) ? a_mag_in : b_mag_in};
                        rem_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                StCalc: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (is_div_op(op_q)) begin
                        acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], div_ge};
                        rem_q            <= div_rem;
                    end else begin
                        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    end
                end
                StFinish: begin
                    hi_q   <= fin_hi;
                    lo_q   <= fin_lo;
                    done_q <= 1'b1;
                    dbz_q  <= is_div_op(op_q) && div_zero;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/div_by_zero are queued at
// launch from a behavioural model and compared when done pulses.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] operand_a = '0, operand_b = '0, write_data = '0;
    logic        hi_write = 1'b0, lo_write = 1'b0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi_out, lo_out;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .hi_write   (hi_write),
        .lo_write   (lo_write),
        .write_data (write_data),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        up;
        exp_t               e;
        sa    = {{32{a[31]}}, a};
        sb    = {{32{b[31]}}, b};
        e.dbz = 1'b0;
        case (o)
            2'd0: begin
                sp = sa * sb;
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            2'd1: begin
                up = {32'b0, a} * {32'b0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi  = a;
                    e.lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                end else if (o == 2'd2) begin
                    sp = sa / sb;
                    e.lo = sp[31:0];
                    sp = sa % sb;
                    e.hi = sp[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op        = o;
        operand_a = a;
        operand_b = b;
        start     = 1'b1;
        sb_q.push_back(model(o, a, b));
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int already, input string tag);
        int   cycles;
        exp_t e;
        cycles = already;
        while (!done && cycles < 60) begin
            tick();
            cycles++;
        end
        check({tag, "_done_seen"}, {63'b0, done}, 64'd1);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'(sb_q.size()), 64'd1);
            return;
        end
        e = sb_q.pop_front();
        if (!done) return;
        check({tag, "_latency"}, 64'(cycles), 64'd33);
        check({tag, "_busy_low"}, {63'b0, busy}, 64'd0);
        check({tag, "_hi"}, {32'b0, hi_out}, {32'b0, e.hi});
        check({tag, "_lo"}, {32'b0, lo_out}, {32'b0, e.lo});
        check({tag, "_dbz"}, {63'b0, div_by_zero}, {63'b0, e.dbz});
    endtask

    initial begin
        int pulses;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        tick();
        tick();
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        check("rst_hi", {32'b0, hi_out}, 64'd0);
        check("rst_lo", {32'b0, lo_out}, 64'd0);
        reset = 1'b1;
        tick();

        launch(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy_high", {63'b0, busy}, 64'd1);
        wait_done(0, "multu_max");
        check("multu_max_hi_const", {32'b0, hi_out}, 64'hFFFF_FFFE);
        check("multu_max_lo_const", {32'b0, lo_out}, 64'h1);
        tick();
        check("done_one_cycle", {63'b0, done}, 64'd0);

        // Back-to-back: each launch happens in the cycle done is high.
        launch(2'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done(0, "mult_neg");
        launch(2'd0, 32'h8000_0000, 32'h8000_0000);
        wait_done(0, "mult_min");
        launch(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, "div_neg");
        check("div_neg_lo_const", {32'b0, lo_out}, 64'hFFFF_FFFD);
        launch(2'd3, 32'd7, 32'd2);
        wait_done(0, "divu_small");
        launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, "div_ovf");
        check("div_ovf_lo_const", {32'b0, lo_out}, 64'h8000_0000);
        launch(2'd3, 32'd100, 32'd0);
        wait_done(0, "divu_zero");
        launch(2'd2, 32'd9, 32'd3);
        wait_done(0, "div_after_zero");
        tick();

        hi_write   = 1'b1;
        write_data = 32'h1234;
        tick();
        hi_write = 1'b0;
        check("mthi", {32'b0, hi_out}, 64'h1234);
        lo_write   = 1'b1;
        write_data = 32'hABCD;
        tick();
        lo_write = 1'b0;
        check("mtlo", {32'b0, lo_out}, 64'hABCD);

        // Start with a same-cycle MTLO, then a start+MTHI attempt while busy.
        lo_write   = 1'b1;
        write_data = 32'h55;
        launch(2'd1, 32'd2, 32'd3);
        lo_write = 1'b0;
        check("start_write_lo", {32'b0, lo_out}, 64'h55);
        repeat (4) tick();
        start      = 1'b1;
        op         = 2'd3;
        operand_a  = 32'd9;
        operand_b  = 32'd9;
        hi_write   = 1'b1;
        write_data = 32'hDEAD;
        tick();
        start    = 1'b0;
        hi_write = 1'b0;
        check("busy_mthi_ignored", {32'b0, hi_out}, 64'h1234);
        wait_done(5, "busy_ignore");
        tick();
        check("busy_start_ignored", {63'b0, busy}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i == 5) ? 32'd0 : $urandom;
            launch(ro, ra, rb);
            wait_done(0, "random");
        end

        // Reset mid-DIV: no scoreboard entry since the op is aborted.
        op        = 2'd2;
        operand_a = 32'd100;
        operand_b = 32'd7;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hi", {32'b0, hi_out}, 64'd0);
        check("abort_lo", {32'b0, lo_out}, 64'd0);
        pulses = 0;
        repeat (2) begin
            tick();
            if (done) pulses++;
        end
        reset = 1'b1;
        repeat (40) begin
            tick();
            if (done) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);

        launch(2'd1, 32'd5, 32'd5);
        wait_done(0, "multu_after_reset");
        check("multu_25_const", {32'b0, lo_out}, 64'd25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file and takes its two read ports (rs, rt) as operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the results in HI/LO for MFHI/MFLO. The pipeline stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; iteration count equals `WIDTH`.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch operation `op` using `operand_a` and `operand_b`; sampled only while idle.
- `op`  in  2  operation: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU.
- `operand_a`  in  WIDTH  rs value (multiplicand / dividend), from register file `data_out_1`.
- `operand_b`  in  WIDTH  rt value (multiplier / divisor), from register file `data_out_2`.
- `hi_write`  in  1  MTHI: load `write_data` into HI.
- `lo_write`  in  1  MTLO: load `write_data` into LO.
- `write_data`  in  WIDTH  data for MTHI/MTLO.
- `busy`  out  1  operation in progress; new starts and MTHI/MTLO writes are ignored.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `div_by_zero`  out  1  pulses with `done` when a DIV/DIVU had `operand_b == 0`.
- `hi_out`  out  WIDTH  HI register.
- `lo_out`  out  WIDTH  LO register.

## Operation
- States: IDLE → CALC → FINISH → IDLE.
- **IDLE:**
  - On `start`: latch `op`, latch the original `operand_a` and `operand_b`, and latch the magnitudes.
  - Signed ops (MULT, DIV) take the absolute value of each operand. Unsigned ops take the operands as-is.
  - Clear the iteration counter and go to CALC.
- **CALC, multiply:** radix-2 shift-add over a 2·WIDTH accumulator, one bit per cycle.
- **CALC, divide:** restoring division, one quotient bit per cycle. The remainder register is WIDTH+1 bits so the trial subtraction is unsigned-exact.
- **CALC exit:** after `WIDTH` iterations, go to FINISH.
- **FINISH, sign fix-up:**
  - MULT: negate the 64-bit product if `a[31]^b[31]`.
  - DIV: negate the quotient if `a[31]^b[31]`; negate the remainder if `a[31]`.
  - Two's-complement arithmetic, truncated to WIDTH.
- **FINISH, results:**
  - Multiply: HI = upper half, LO = lower half.
  - Divide: LO = quotient, HI = remainder.
- **Divide by zero**, both DIV and DIVU:
  - Full latency is still taken.
  - Forced result: HI = original `operand_a`, LO = all ones.
  - `div_by_zero` pulses.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This is not an error.
- **MTHI/MTLO:** honoured only in IDLE, written at the clock edge. `hi_write` and `lo_write` together write both registers.
- **`start` with a write in the same IDLE cycle:** both take effect. The write lands now; the operation result overwrites it at FINISH.
- **While busy:** `start`, `hi_write` and `lo_write` are ignored, with no queueing. Operands are not re-sampled.
- **Reset (asynchronous, low):**
  - State goes to IDLE; counters clear.
  - HI = LO = 0; `busy`, `done` and `div_by_zero` go to 0.
  - An in-flight operation is aborted and no `done` is produced.

## Timing
- Start accepted at edge E0.
- `busy` is high from after E0 through the cycle ending at E(WIDTH+1), i.e. 33 cycles for WIDTH = 32.
- Edges E1..E(WIDTH) perform the iterations. E(WIDTH+1) is the FINISH edge: it writes HI/LO.
- In the cycle after E(WIDTH+1), all of these hold at once:
  - `done` = 1
  - `div_by_zero` valid
  - `busy` = 0
  - `hi_out`/`lo_out` carry the new result.
- `done` and `div_by_zero` are registered, one cycle wide.
- A new `start` may be asserted in the same cycle `done` is high; it is accepted at that edge. Back-to-back throughput is one operation per WIDTH+2 cycles.
- `hi_out`/`lo_out` are registered outputs, stable except at IDLE-write edges and FINISH edges.

## Structure
- Package `mdu_pkg` holds:
  - the `op` encodings (MULT, MULTU, DIV, DIVU);
  - the state encoding (IDLE, CALC, FINISH);
  - the default WIDTH constant.
- Single module. The datapath (accumulator, remainder, counter) and the FSM live together; no sub-module is warranted.
- Decoding the instruction into `op`, `start` and the MTHI/MTLO strobes is the control unit's job, not this block's.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001; `done` exactly 33 cycles after the start edge; `busy` low with `done`.
- MULT −3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; MULT 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIVU 7 / 2 → LO = 3, HI = 1; DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIVU 100 / 0 → HI = 0x64, LO = 0xFFFFFFFF, `div_by_zero` = 1 with `done`; the next DIV 9 / 3 → `div_by_zero` = 0.
- Busy rules:
  - MTHI 0x1234 in IDLE → `hi_out` = 0x1234 next cycle.
  - `start` and `hi_write` pulsed at cycle 5 of a MULTU 2 × 3 → ignored; the result is HI = 0, LO = 6.
- Reset mid-operation:
  - Assert `reset` low at cycle 10 of a DIV → `busy` = 0 immediately; HI = LO = 0; no `done` pulse.
  - After release, MULTU 5 × 5 → LO = 25.
